keypad_matrix_driver: RTL and testbench
=======================================

# keypad_matrix_driver

Scanning front end for the 4x3 matrix keypad. Drives the column strobes, samples the row returns, debounces across whole scan frames, and delivers a 12-bit one-hot key code with a one-cycle valid pulse. The output is in the exact format the downstream keypad scan/display path consumes. It sits between the keypad pins and the existing keypad_scan → display → register → seg_controller chain, replacing direct one-hot key wiring.

## Interface
- SCAN_DIV, 1000: clock cycles each column stays driven; must be ≥ 2.
- DEBOUNCE_SCANS, 4: consecutive identical full frames required to accept a press or a release; must be ≥ 1.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- row_in  input  4  keypad row returns, active-low (pulled up externally); asynchronous to clk.
- col_out  output  3  column strobes, active-low one-hot.
- key_onehot  output  12  accepted key, one-hot; bit index = row*3 + col; all-zero when no key is held.
- key_valid  output  1  one-cycle pulse when a new press is accepted.
- key_held  output  1  high while an accepted key remains pressed.

## Operation
- row_in passes through a 2-flop synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1. At the SCAN_DIV-1 count, the synchronized rows for the current column are captured into a 12-bit frame buffer (slot bits col, col+3, col+6, col+9). The column then advances 0→1→2→0.
- Frame end is the capture in column 2. Frame result classes:
  - NONE: zero bits set.
  - SINGLE(k): exactly one bit set.
  - MULTI: two or more bits set. MULTI is treated as NONE for acceptance and as "not released" for release.
- FSM states and transitions (evaluated only at frame end):
  - IDLE: SINGLE(k) → CONFIRM, cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately.
  - CONFIRM: SINGLE(same k) increments cnt. When cnt reaches DEBOUNCE_SCANS: accept → PRESSED. Any other result → IDLE, cnt=0.
  - PRESSED: NONE → RELEASE_CHK, cnt=1. Anything else stays in PRESSED. A different key never replaces the held key.
  - RELEASE_CHK: NONE increments cnt. When cnt reaches DEBOUNCE_SCANS → IDLE. Any non-NONE result → PRESSED.
- Accept: key_onehot ← bit k, key_valid pulses, key_held ← 1.
- Entering IDLE from RELEASE_CHK: key_onehot ← 0, key_held ← 0.
- Width rules: prescaler $clog2(SCAN_DIV) bits; cnt $clog2(DEBOUNCE_SCANS+1) bits, saturating.

## Timing
- Reset values: col_out=3'b110, key_onehot=0, key_valid=0, key_held=0, FSM=IDLE, prescaler=0, cnt=0, frame buffer=0.
- Reset mid-operation clears everything immediately, including an in-flight key_valid.
- Frame period = 3*SCAN_DIV cycles.
- key_valid asserts the cycle after the frame-end capture edge of the DEBOUNCE_SCANS-th matching frame. key_onehot and key_held update on that same cycle.
- key_valid is high for exactly one cycle per accepted press and never re-fires while a key is held.
- Press-to-valid latency: at most (DEBOUNCE_SCANS+1)*3*SCAN_DIV + 3 cycles (synchronizer plus register).
- Release clears key_onehot one cycle after the DEBOUNCE_SCANS-th NONE frame end.
- col_out changes on the cycle after the capture, giving a full slot of settle time before the next sample.

## Structure
- Shared package keypad_pkg holds NUM_ROWS=4, NUM_COLS=3, NUM_KEYS=12, the FSM state enum (IDLE, CONFIRM, PRESSED, RELEASE_CHK), and a popcount/one-hot-check function.
- Sub-module keypad_debounce contains the FSM and cnt. It takes a frame_done strobe plus the 12-bit frame and outputs key_onehot, key_valid and key_held.
- The top level contains the synchronizer, prescaler, column counter and frame buffer.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2, so one frame = 12 cycles.
- Reset release with no press → col_out cycles 110→101→011 every 4 cycles; key_onehot=0 and key_valid never asserts.
- Hold row 1 low while col 2 is active for ≥ 3 frames → exactly one key_valid pulse; key_onehot=12'h020 (bit 5); key_held=1.
- Press for a single frame only, then release → no key_valid; FSM returns to IDLE.
- Press key 0 and key 4 together for 4 frames → no key_valid. Then drop key 4 → key_onehot=12'h001 after 2 frames.
- Hold key 5, press key 11 as well, then release only key 5 → no new key_valid while key 11 is held. key_onehot stays 12'h020 until all keys are released for 2 frames, then goes to 0.
- Assert rst mid-CONFIRM and mid-PRESSED → all outputs return to reset values asynchronously. A full re-debounce is required after reset deasserts.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and frame-classification helpers
// for the 4x3 keypad scanning front end.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int COL_W    = 2;

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE_CHK} kp_state_e;

  function automatic logic [3:0] popcount(input logic [NUM_KEYS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return popcount(v) == 4'd1;
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a single key after DEBOUNCE_SCANS identical
// frames and releases it after DEBOUNCE_SCANS empty frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frame_done,
  input  logic [NUM_KEYS-1:0] i_frame,
  output logic [NUM_KEYS-1:0] o_key_onehot,
  output logic                o_key_valid,
  output logic                o_key_held
);
  localparam int             CW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  C_TGT = CW'(DEBOUNCE_SCANS);

  kp_state_e           r_state, w_state;
  logic [CW-1:0]       r_cnt, w_cnt, w_cnt_inc;
  logic [NUM_KEYS-1:0] r_cand, w_cand, r_key, w_key;
  logic                r_valid, w_valid, r_held, w_held;
  logic                w_none, w_single;

  assign w_none    = (i_frame == '0);
  assign w_single  = is_onehot(i_frame);
  assign w_cnt_inc = (r_cnt == C_TGT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_cand  <= w_cand;
      r_key   <= w_key;
      r_valid <= w_valid;
      r_held  <= w_held;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_cand  = r_cand;
    w_key   = r_key;
    w_valid = 1'b0;
    w_held  = r_held;
    if (i_frame_done) begin
      case (r_state)
        IDLE: if (w_single) begin
          w_cand = i_frame;
          if (DEBOUNCE_SCANS == 1) begin
            w_state = PRESSED; w_cnt = '0;
            w_key = i_frame; w_valid = 1'b1; w_held = 1'b1;
          end else begin
            w_state = CONFIRM; w_cnt = CW'(1);
          end
        end
        CONFIRM: if (w_single && i_frame == r_cand) begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == C_TGT) begin
            w_state = PRESSED; w_cnt = '0;
            w_key = r_cand; w_valid = 1'b1; w_held = 1'b1;
          end
        end else begin
          w_state = IDLE; w_cnt = '0;
        end
        // MULTI counts as "still pressed"; a second key never displaces the held one
        PRESSED: if (w_none) begin
          if (DEBOUNCE_SCANS == 1) begin
            w_state = IDLE; w_cnt = '0; w_key = '0; w_held = 1'b0;
          end else begin
            w_state = RELEASE_CHK; w_cnt = CW'(1);
          end
        end
        RELEASE_CHK: if (w_none) begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc == C_TGT) begin
            w_state = IDLE; w_cnt = '0; w_key = '0; w_held = 1'b0;
          end
        end else begin
          w_state = PRESSED; w_cnt = '0;
        end
        default: begin
          w_state = IDLE; w_cnt = '0;
        end
      endcase
    end
  end

  assign o_key_onehot = r_key;
  assign o_key_valid  = r_valid;
  assign o_key_held   = r_held;
endmodule

// File: rtl/keypad_matrix_driver.sv
// Keypad scan front end: row synchronizer, column strobe sequencer and frame
// buffer feeding the debounce FSM.
module keypad_matrix_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic                key_valid,
  output logic                key_held
);
  localparam int            DW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] r_row_s1, r_row_s2;
  logic [DW-1:0]       r_div;
  logic [COL_W-1:0]    r_col;
  logic [NUM_KEYS-1:0] r_frame, w_frame_nxt;
  logic                w_cap, w_frame_done;

  assign w_cap        = (r_div == DIV_MAX);
  assign w_frame_done = w_cap && (r_col == COL_W'(NUM_COLS - 1));

  // Debounce sees the frame including the slots being captured this edge
  always_comb begin
    w_frame_nxt = r_frame;
    for (int r = 0; r < NUM_ROWS; r++)
      w_frame_nxt[r*NUM_COLS + int'(r_col)] = ~r_row_s2[r];
  end

  always_comb begin
    col_out = '1;
    for (int c = 0; c < NUM_COLS; c++)
      col_out[c] = (r_col != COL_W'(c));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_div    <= '0;
      r_col    <= '0;
      r_frame  <= '0;
    end else begin
      r_row_s1 <= row_in;
      r_row_s2 <= r_row_s1;
      r_div    <= w_cap ? '0 : r_div + 1'b1;
      if (w_cap) begin
        r_frame <= w_frame_nxt;
        r_col   <= (r_col == COL_W'(NUM_COLS - 1)) ? '0 : r_col + 1'b1;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_deb (
    .clk          (clk),
    .rst          (rst),
    .i_frame_done (w_frame_done),
    .i_frame      (w_frame_nxt),
    .o_key_onehot (key_onehot),
    .o_key_valid  (key_valid),
    .o_key_held   (key_held)
  );
endmodule

// File: tb/tb_keypad_matrix_driver.sv
// Directed bench for keypad_matrix_driver with a passive keypad model
// (SCAN_DIV=4, DEBOUNCE_SCANS=2: one frame = 12 cycles).
module tb_keypad_matrix_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in;
  logic [2:0]  col_out;
  logic [11:0] key_onehot;
  logic        key_valid, key_held;
  logic [11:0] keys = '0;
  int          n_tests = 0, n_fail = 0;
  int          vcnt = 0, v0;

  always #5 clk = ~clk;

  keypad_matrix_driver #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_onehot(key_onehot), .key_valid(key_valid), .key_held(key_held)
  );

  // Pressed switch shorts its row to its column strobe
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      row_in[r] = ~|(keys[r*3 +: 3] & ~col_out);
  end

  always @(posedge clk) if (key_valid) vcnt <= vcnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // From a negedge just after posedge k, land on the negedge after posedge k+n
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves us at a negedge with no posedge yet seen out of reset ("P0")
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // idle scanning
    keys = '0;
    do_reset();
    chk("rst_col", col_out, 3'b110);
    chk("rst_key", key_onehot, 12'h000);
    chk("rst_vld", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    v0 = vcnt;
    wait_cyc(3);  chk("col0_hold", col_out, 3'b110);
    wait_cyc(1);  chk("col1", col_out, 3'b101);
    wait_cyc(4);  chk("col2", col_out, 3'b011);
    wait_cyc(4);  chk("col_wrap", col_out, 3'b110);
    wait_cyc(48);
    chk("idle_nvld", vcnt - v0, 0);
    chk("idle_key", key_onehot, 12'h000);

    // key 5 press, then key 11 added, key 5 dropped, all released
    keys = 12'h020;
    do_reset();
    v0 = vcnt;
    wait_cyc(23); chk("k5_early_vld", key_valid, 1'b0);
                  chk("k5_early_key", key_onehot, 12'h000);
    wait_cyc(1);  chk("k5_vld", key_valid, 1'b1);
                  chk("k5_key", key_onehot, 12'h020);
                  chk("k5_held", key_held, 1'b1);
    wait_cyc(1);  chk("k5_pulse1", key_valid, 1'b0);
    wait_cyc(11); keys = 12'h820;
    wait_cyc(24); chk("multi_key", key_onehot, 12'h020);
                  chk("multi_nvld", vcnt - v0, 1);
    keys = 12'h800;
    wait_cyc(36); chk("k11_key", key_onehot, 12'h020);
                  chk("k11_held", key_held, 1'b1);
                  chk("k11_nvld", vcnt - v0, 1);
    keys = '0;
    wait_cyc(23); chk("rel_early", key_onehot, 12'h020);
    wait_cyc(1);  chk("rel_key", key_onehot, 12'h000);
                  chk("rel_held", key_held, 1'b0);
                  chk("rel_nvld", vcnt - v0, 1);

    // single-frame press is rejected, FSM back in IDLE
    keys = 12'h020;
    do_reset();
    v0 = vcnt;
    wait_cyc(12); keys = '0;
    wait_cyc(48); chk("blip_nvld", vcnt - v0, 0);
                  chk("blip_key", key_onehot, 12'h000);
    keys = 12'h008;
    wait_cyc(24); chk("k3_vld", key_valid, 1'b1);
                  chk("k3_key", key_onehot, 12'h008);

    // two keys together, then drop one
    keys = 12'h011;
    do_reset();
    v0 = vcnt;
    wait_cyc(48); chk("two_nvld", vcnt - v0, 0);
                  chk("two_key", key_onehot, 12'h000);
    keys = 12'h001;
    wait_cyc(23); chk("k0_early", key_valid, 1'b0);
    wait_cyc(1);  chk("k0_vld", key_valid, 1'b1);
                  chk("k0_key", key_onehot, 12'h001);

    // reset mid-CONFIRM
    keys = 12'h020;
    do_reset();
    wait_cyc(16); chk("pre_col", col_out, 3'b101);
    rst = 1'b0; #1;
    chk("arst_col", col_out, 3'b110);
    chk("arst_key", key_onehot, 12'h000);
    do_reset();
    wait_cyc(12); chk("redeb_early_vld", key_valid, 1'b0);
                  chk("redeb_early_key", key_onehot, 12'h000);
    wait_cyc(12); chk("redeb_vld", key_valid, 1'b1);
                  chk("redeb_key", key_onehot, 12'h020);

    // reset mid-PRESSED while key_valid is high
    rst = 1'b0; #1;
    chk("arst2_vld", key_valid, 1'b0);
    chk("arst2_key", key_onehot, 12'h000);
    chk("arst2_held", key_held, 1'b0);
    do_reset();
    v0 = vcnt;
    wait_cyc(23); chk("redeb2_held", key_held, 1'b0);
    wait_cyc(1);  chk("redeb2_vld", key_valid, 1'b1);
                  chk("redeb2_key", key_onehot, 12'h020);
    wait_cyc(2);  chk("redeb2_cnt", vcnt - v0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
